uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an internal transmit FIFO, runtime baud divisor, selectable parity and 1/2 stop bits. It succeeds the fixed-format 8N1 transmitter, replacing the fixed clock-rate/baud-rate parameters with a runtime divisor and the tx_start pulse with a valid/ready push interface. It sits between a bus-side register block or DMA (writer) and the serial TX pin.

---
 rtl/uart_tx_fifo.sv | 115 +++++++++++
 tb/tb_uart_tx_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with transmit FIFO, runtime baud divisor, parity and 1/2 stop bits
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic                          tx_en,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic                          tx_line,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] shreg;
  logic [DIV_W-1:0] div_l, cnt;
  logic [BW-1:0] bit_idx;
  logic par, par_en, par_odd, two_l, stop2;
  logic push, pop, last, frame_end;
  assign wr_ready  = fifo_count != FULL;
  assign push      = wr_valid && wr_ready;
  assign last      = cnt == div_l - DIV_W'(1);
  assign frame_end = state == STOP && last && (stop2 || !two_l);
  // A new frame is popped from IDLE or straight out of the final stop period.
  assign pop       = tx_en && fifo_count != '0 && (state == IDLE || frame_end);
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      state      <= IDLE;
      shreg      <= '0;
      div_l      <= DIV_W'(1);
      cnt        <= '0;
      bit_idx    <= '0;
      par        <= 1'b0;
      par_en     <= 1'b0;
      par_odd    <= 1'b0;
      two_l      <= 1'b0;
      stop2      <= 1'b0;
      tx_line    <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(push);
      rd_ptr     <= rd_ptr + AW'(pop);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      tx_done    <= frame_end;
      if (pop) begin
        shreg   <= mem[rd_ptr];
        par     <= ^mem[rd_ptr];
        div_l   <= baud_div == '0 ? DIV_W'(1) : baud_div;
        par_en  <= parity_mode == 2'b01 || parity_mode == 2'b10;
        par_odd <= parity_mode == 2'b10;
        two_l   <= two_stop;
        cnt     <= '0;
        bit_idx <= '0;
        stop2   <= 1'b0;
        state   <= START;
        tx_line <= 1'b0;
        tx_busy <= 1'b1;
      end else if (state != IDLE) begin
        cnt <= last ? '0 : cnt + DIV_W'(1);
        if (last) begin
          case (state)
            START: begin
              state   <= DATA;
              tx_line <= shreg[0];
            end
            DATA: begin
              if (bit_idx == LAST_BIT) begin
                state   <= par_en ? PARITY : STOP;
                tx_line <= par_en ? par ^ par_odd : 1'b1;
              end else begin
                bit_idx <= bit_idx + BW'(1);
                shreg   <= shreg >> 1;
                tx_line <= shreg[1];
              end
            end
            PARITY: begin
              state   <= STOP;
              tx_line <= 1'b1;
            end
            default: begin
              if (two_l && !stop2) stop2 <= 1'b1;
              else begin
                state   <= IDLE;
                tx_line <= 1'b1;
                tx_busy <= 1'b0;
              end
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed plus randomized bench with a frame-level reference model of the serial line
module tb_uart_tx_fifo;
  logic        clk, reset_n;
  logic [7:0]  wr_data;
  logic        wr_valid, wr_ready, tx_en;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        two_stop, tx_line, tx_busy, tx_done;
  logic [4:0]  fifo_count;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q [$];
  int start_cyc [$];
  int done_cyc [$];
  logic active = 1'b0;
  logic done_due = 1'b0;
  logic [15:0] fbits;
  int flen, fd, fcyc;
  logic [7:0] mb;
  uart_tx_fifo dut (
    .clk(clk), .reset_n(reset_n), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .tx_en(tx_en), .baud_div(baud_div), .parity_mode(parity_mode), .two_stop(two_stop),
    .tx_line(tx_line), .tx_busy(tx_busy), .tx_done(tx_done), .fifo_count(fifo_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask
  // Reference: a frame is start(0), data LSB first, optional parity, one or two stop slots, each D cycles.
  always @(negedge clk) begin
    if (!reset_n) begin
      active   = 1'b0;
      done_due = 1'b0;
    end else begin
      chk("tx_done", 32'(tx_done), 32'(done_due));
      if (done_due) done_cyc.push_back(cyc);
      done_due = 1'b0;
      if (!active && tx_line === 1'b0) begin
        if (exp_q.size() == 0) chk("spurious_frame", 32'(1), 32'(0));
        else begin
          mb = exp_q.pop_front();
          fd = baud_div == 0 ? 1 : int'(baud_div);
          fbits = '1;
          fbits[0] = 1'b0;
          for (int i = 0; i < 8; i++) fbits[1+i] = mb[i];
          flen = 9;
          if (parity_mode == 2'b01 || parity_mode == 2'b10) begin
            fbits[flen] = (^mb) ^ (parity_mode == 2'b10);
            flen++;
          end
          flen += two_stop ? 2 : 1;
          fcyc = 0;
          active = 1'b1;
          start_cyc.push_back(cyc);
        end
      end
      if (active) begin
        chk("tx_line", 32'(tx_line), 32'(fbits[fcyc/fd]));
        chk("tx_busy", 32'(tx_busy), 32'(1));
        fcyc++;
        if (fcyc == flen * fd) begin
          active   = 1'b0;
          done_due = 1'b1;
        end
      end else begin
        chk("idle_line", 32'(tx_line), 32'(1));
        chk("idle_busy", 32'(tx_busy), 32'(0));
      end
      chk("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
      chk("wr_ready", 32'(wr_ready), 32'(exp_q.size() != 16));
    end
  end
  task automatic push(input logic [7:0] d, output logic acc);
    wr_data  = d;
    wr_valid = 1'b1;
    acc      = wr_ready;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    if (acc) exp_q.push_back(d);
  endtask
  task automatic wait_idle(input int limit);
    int n;
    for (n = 0; n < limit; n++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !active && !done_due && !tx_busy) break;
    end
    if (n == limit) chk("drain_timeout", 32'(0), 32'(1));
  endtask
  task automatic clear_log();
    start_cyc.delete();
    done_cyc.delete();
  endtask
  initial begin
    logic acc;
    int push_cyc;
    reset_n = 1'b0; wr_data = '0; wr_valid = 1'b0; tx_en = 1'b0;
    baud_div = 16'd4; parity_mode = 2'b00; two_stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_line", 32'(tx_line), 32'(1));
    chk("rst_busy", 32'(tx_busy), 32'(0));
    chk("rst_done", 32'(tx_done), 32'(0));
    chk("rst_count", 32'(fifo_count), 32'(0));
    chk("rst_ready", 32'(wr_ready), 32'(1));
    reset_n = 1'b1;
    tx_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_log();
    push(8'hA5, acc);
    push_cyc = cyc;
    wait_idle(200);
    chk("t1_frames", 32'(done_cyc.size()), 32'(1));
    chk("t1_latency", 32'(start_cyc[0] - push_cyc), 32'(1));
    chk("t1_len", 32'(done_cyc[0] - start_cyc[0]), 32'(40));
    parity_mode = 2'b01;
    clear_log();
    push(8'hA5, acc);
    wait_idle(200);
    chk("t2_even_len", 32'(done_cyc[0] - start_cyc[0]), 32'(44));
    parity_mode = 2'b10;
    clear_log();
    push(8'hA5, acc);
    wait_idle(200);
    chk("t2_odd_len", 32'(done_cyc[0] - start_cyc[0]), 32'(44));
    parity_mode = 2'b00; two_stop = 1'b1; baud_div = 16'd3;
    clear_log();
    push(8'h00, acc);
    push(8'hFF, acc);
    wait_idle(300);
    chk("t3_frames", 32'(done_cyc.size()), 32'(2));
    chk("t3_done_gap", 32'(done_cyc[1] - done_cyc[0]), 32'(33));
    chk("t3_back2back", 32'(start_cyc[1]), 32'(done_cyc[0]));
    two_stop = 1'b0; baud_div = 16'd2; tx_en = 1'b0;
    clear_log();
    for (int i = 0; i < 16; i++) begin
      push(8'(i * 17 + 3), acc);
      chk("t4_accept", 32'(acc), 32'(1));
    end
    push(8'hEE, acc);
    chk("t4_reject17", 32'(acc), 32'(0));
    chk("t4_full_count", 32'(fifo_count), 32'(16));
    chk("t4_full_ready", 32'(wr_ready), 32'(0));
    repeat (10) @(posedge clk);
    #1;
    chk("t4_line_held", 32'(tx_line), 32'(1));
    tx_en = 1'b1;
    wait_idle(2000);
    chk("t4_frames", 32'(done_cyc.size()), 32'(16));
    baud_div = 16'd4;
    clear_log();
    push(8'h3C, acc);
    push(8'hC3, acc);
    repeat (15) @(posedge clk);
    #1;
    baud_div = 16'd8;
    wait_idle(400);
    chk("t5_first_len", 32'(done_cyc[0] - start_cyc[0]), 32'(40));
    chk("t5_second_len", 32'(done_cyc[1] - done_cyc[0]), 32'(80));
    baud_div = 16'd0;
    clear_log();
    push(8'h5A, acc);
    wait_idle(100);
    chk("t5_div0_len", 32'(done_cyc[0] - start_cyc[0]), 32'(10));
    for (int r = 0; r < 10; r++) begin
      int k;
      baud_div = 16'($urandom_range(0, 5));
      parity_mode = 2'($urandom_range(0, 3));
      two_stop = 1'($urandom_range(0, 1));
      k = $urandom_range(1, 5);
      clear_log();
      for (int j = 0; j < k; j++) push(8'($urandom_range(0, 255)), acc);
      wait_idle(1000);
      chk("rand_frames", 32'(done_cyc.size()), 32'(k));
    end
    baud_div = 16'd4; parity_mode = 2'b00; two_stop = 1'b0;
    push(8'h81, acc);
    push(8'h42, acc);
    push(8'h24, acc);
    repeat (15) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_async_line", 32'(tx_line), 32'(1));
    chk("t6_async_busy", 32'(tx_busy), 32'(0));
    chk("t6_async_count", 32'(fifo_count), 32'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("t6_no_residual", 32'(tx_busy), 32'(0));
    chk("t6_count_after", 32'(fifo_count), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
